// File: rtl/prefetch_pkg.sv
// Shared types and constants for the byte prefetch queue.
package prefetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  localparam logic [31:0] RESET_VEC     = 32'h000F_8000;
  localparam int          DEPTH_DEFAULT = 8;

endpackage

// File: rtl/prefetch_fifo.sv
// Byte storage for the prefetch queue: circular buffer with one extra pointer bit
// so full and empty are told apart by the MSB.
module prefetch_fifo
  import prefetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int W     = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   clear_i,
  input  logic [W-1:0]           data_i,
  output logic [W-1:0]           data_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, rd_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         push_ok, pop_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_o = wr_q - rd_q;
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  // Empty reads as zero so the head output is defined out of reset.
  assign data_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (clear_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok && !clear_i) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/prefetch_queue.sv
// Instruction byte prefetcher: one outstanding bus read feeding a small FIFO.
// Define PREFETCH_BYPASS_EN to forward a returning byte straight to q_data when the queue is empty.
module prefetch_queue
  import prefetch_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int ADDR_W = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   locked,
  output logic [ADDR_W-1:0]      mem_address,
  output logic                   mem_rd,
  input  logic [7:0]             mem_in,
  input  logic                   mem_ready,
  input  logic                   bus_busy,
  input  logic                   flush,
  input  logic [ADDR_W-1:0]      flush_addr,
  output logic [7:0]             q_data,
  output logic                   q_valid,
  input  logic                   q_pop,
  output logic [$clog2(DEPTH):0] q_count,
  output logic [1:0]             dbg_state_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_ptr_q, fetch_ptr_d;
  logic              issue, push, clr, bypass;
  logic              fifo_empty, fifo_full;
  logic [7:0]        fifo_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      fetch_ptr_q <= ADDR_W'(RESET_VEC);
    end else begin
      state_q     <= state_d;
      fetch_ptr_q <= fetch_ptr_d;
    end
  end

  // With locked low every default holds, so the whole block freezes.
  always_comb begin
    state_d     = state_q;
    fetch_ptr_d = fetch_ptr_q;
    issue       = 1'b0;
    push        = 1'b0;
    clr         = 1'b0;
    bypass      = 1'b0;
    if (locked) begin
      case (state_q)
        S_IDLE: begin
          if (!flush && !bus_busy && !fifo_full) begin
            issue   = 1'b1;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_ready) begin
            state_d = S_IDLE;
            if (!flush) begin
              fetch_ptr_d = fetch_ptr_q + ADDR_W'(1);
`ifdef PREFETCH_BYPASS_EN
              bypass = fifo_empty;
              push   = !(fifo_empty && q_pop);
`else
              push   = 1'b1;
`endif
            end
          end else if (flush) begin
            state_d = S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (mem_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
      if (flush) begin
        clr         = 1'b1;
        fetch_ptr_d = flush_addr;
      end
    end
  end

  // Reset gates the request combinationally so an abandoned read drops at once.
  assign mem_rd      = reset_n && (issue || (state_q != S_IDLE));
  assign mem_address = fetch_ptr_q;
  assign q_valid     = !fifo_empty || bypass;
  assign q_data      = bypass ? mem_in : fifo_data;
  assign dbg_state_o = state_q;

  prefetch_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push_i  (push),
    .pop_i   (q_pop && locked && !flush && !bypass),
    .clear_i (clr),
    .data_i  (mem_in),
    .data_o  (fifo_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (q_count)
  );

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue: one task per scenario, inline checks, one summary line.
module tb_prefetch_queue;

  logic        clock = 1'b0;
  logic        reset_n, locked, mem_rd, mem_ready, bus_busy, flush, q_valid, q_pop;
  logic [31:0] mem_address, flush_addr;
  logic [7:0]  mem_in, q_data;
  logic [3:0]  q_count;
  logic [1:0]  dbg_state;
  int          passed = 0;
  int          total  = 0;

  always #5 clock = ~clock;

  prefetch_queue #(.DEPTH(8), .ADDR_W(32)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .locked      (locked),
    .mem_address (mem_address),
    .mem_rd      (mem_rd),
    .mem_in      (mem_in),
    .mem_ready   (mem_ready),
    .bus_busy    (bus_busy),
    .flush       (flush),
    .flush_addr  (flush_addr),
    .q_data      (q_data),
    .q_valid     (q_valid),
    .q_pop       (q_pop),
    .q_count     (q_count),
    .dbg_state_o (dbg_state)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic bb);
    reset_n = 1'b0; locked = 1'b1; bus_busy = bb; mem_ready = 1'b0; mem_in = 8'h00;
    flush = 1'b0; flush_addr = 32'h0; q_pop = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    #1;
  endtask

  // Starts in a cycle where IDLE issues; memory answers one cycle later.
  task automatic fetch_byte(input logic [7:0] d, input logic [31:0] a);
    mem_ready = 1'b0; #1;
    total++; if (mem_rd !== 1'b1) $display("FAIL fetch_rd got %b exp 1", mem_rd); else passed++;
    total++; if (mem_address !== a) $display("FAIL fetch_addr got %h exp %h", mem_address, a); else passed++;
    step();
    mem_ready = 1'b1; mem_in = d; #1;
    step();
    mem_ready = 1'b0; #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; locked = 1'b1; bus_busy = 1'b0; mem_ready = 1'b0; mem_in = 8'h00;
    flush = 1'b0; flush_addr = 32'h0; q_pop = 1'b0;
    step();
    total++; if (mem_rd !== 1'b0) $display("FAIL rst_rd got %b exp 0", mem_rd); else passed++;
    total++; if (q_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", q_valid); else passed++;
    total++; if (q_data !== 8'h00) $display("FAIL rst_data got %h exp 00", q_data); else passed++;
    total++; if (q_count !== 4'd0) $display("FAIL rst_count got %0d exp 0", q_count); else passed++;
    total++; if (mem_address !== 32'h000F8000) $display("FAIL rst_addr got %h exp 000f8000", mem_address); else passed++;
    total++; if (dbg_state !== 2'd0) $display("FAIL rst_state got %0d exp 0", dbg_state); else passed++;
    reset_n = 1'b1;
    step();
    total++; if (dbg_state !== 2'd1) $display("FAIL rst_wait_state got %0d exp 1", dbg_state); else passed++;
    reset_n = 1'b0; #1;
    total++; if (mem_rd !== 1'b0) $display("FAIL rst_abandon_rd got %b exp 0", mem_rd); else passed++;
    total++; if (dbg_state !== 2'd0) $display("FAIL rst_abandon_state got %0d exp 0", dbg_state); else passed++;
  endtask

  task automatic test_basic_fetch();
    do_reset(1'b0);
    fetch_byte(8'h90, 32'h000F8000);
    fetch_byte(8'hEB, 32'h000F8001);
    fetch_byte(8'hFE, 32'h000F8002);
    total++; if (q_count !== 4'd3) $display("FAIL basic_count got %0d exp 3", q_count); else passed++;
    total++; if (q_data !== 8'h90) $display("FAIL basic_data got %h exp 90", q_data); else passed++;
    total++; if (q_valid !== 1'b1) $display("FAIL basic_valid got %b exp 1", q_valid); else passed++;
  endtask

  task automatic test_full();
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) fetch_byte(8'h10 + 8'(i), 32'h000F8000 + 32'(i));
    total++; if (q_count !== 4'd8) $display("FAIL full_count got %0d exp 8", q_count); else passed++;
    for (int i = 0; i < 3; i++) begin
      total++; if (mem_rd !== 1'b0) $display("FAIL full_no_rd got %b exp 0", mem_rd); else passed++;
      step();
    end
    q_pop = 1'b1; #1;
    total++; if (q_data !== 8'h10) $display("FAIL full_head got %h exp 10", q_data); else passed++;
    step();
    q_pop = 1'b0; #1;
    total++; if (q_count !== 4'd7) $display("FAIL full_pop_count got %0d exp 7", q_count); else passed++;
    total++; if (q_data !== 8'h11) $display("FAIL full_next_head got %h exp 11", q_data); else passed++;
    fetch_byte(8'h18, 32'h000F8008);
    total++; if (q_count !== 4'd8) $display("FAIL full_refill_count got %0d exp 8", q_count); else passed++;
    total++; if (mem_rd !== 1'b0) $display("FAIL full_refill_rd got %b exp 0", mem_rd); else passed++;
  endtask

  task automatic test_flush_wait();
    do_reset(1'b0);
    fetch_byte(8'h90, 32'h000F8000);
    step();
    flush = 1'b1; flush_addr = 32'h00001234; #1;
    step();
    flush = 1'b0; #1;
    total++; if (q_valid !== 1'b0) $display("FAIL flw_valid got %b exp 0", q_valid); else passed++;
    total++; if (q_count !== 4'd0) $display("FAIL flw_count got %0d exp 0", q_count); else passed++;
    total++; if (dbg_state !== 2'd2) $display("FAIL flw_state got %0d exp 2", dbg_state); else passed++;
    mem_ready = 1'b1; mem_in = 8'hAA; #1;
    total++; if (q_valid !== 1'b0) $display("FAIL flw_stale_valid got %b exp 0", q_valid); else passed++;
    step();
    mem_ready = 1'b0; #1;
    total++; if (q_count !== 4'd0) $display("FAIL flw_drop_count got %0d exp 0", q_count); else passed++;
    total++; if (dbg_state !== 2'd0) $display("FAIL flw_idle got %0d exp 0", dbg_state); else passed++;
    fetch_byte(8'h55, 32'h00001234);
    total++; if (q_data !== 8'h55) $display("FAIL flw_new_data got %h exp 55", q_data); else passed++;
    total++; if (mem_address !== 32'h00001235) $display("FAIL flw_next_addr got %h exp 00001235", mem_address); else passed++;
  endtask

  task automatic test_flush_same_cycle();
    do_reset(1'b0);
    step();
    mem_ready = 1'b1; mem_in = 8'h77; flush = 1'b1; flush_addr = 32'h00002000; #1;
    step();
    mem_ready = 1'b0; flush = 1'b0; #1;
    total++; if (q_count !== 4'd0) $display("FAIL fls_count got %0d exp 0", q_count); else passed++;
    total++; if (dbg_state !== 2'd0) $display("FAIL fls_state got %0d exp 0", dbg_state); else passed++;
    total++; if (mem_address !== 32'h00002000) $display("FAIL fls_addr got %h exp 00002000", mem_address); else passed++;
  endtask

  task automatic test_bus_busy();
    do_reset(1'b1);
    for (int i = 0; i < 5; i++) begin
      total++; if (mem_rd !== 1'b0) $display("FAIL busy_rd got %b exp 0", mem_rd); else passed++;
      step();
    end
    bus_busy = 1'b0; #1;
    total++; if (mem_rd !== 1'b1) $display("FAIL busy_release_rd got %b exp 1", mem_rd); else passed++;
    step();
    total++; if (dbg_state !== 2'd1) $display("FAIL busy_state got %0d exp 1", dbg_state); else passed++;
  endtask

  task automatic test_locked();
    do_reset(1'b0);
    locked = 1'b0; #1;
    total++; if (mem_rd !== 1'b0) $display("FAIL lock_rd got %b exp 0", mem_rd); else passed++;
    step();
    total++; if (dbg_state !== 2'd0) $display("FAIL lock_state got %0d exp 0", dbg_state); else passed++;
    locked = 1'b1; #1;
    total++; if (mem_rd !== 1'b1) $display("FAIL lock_resume_rd got %b exp 1", mem_rd); else passed++;
  endtask

  task automatic test_push_pop();
    do_reset(1'b0);
    fetch_byte(8'h11, 32'h000F8000);
    step();
    mem_ready = 1'b1; mem_in = 8'h22; q_pop = 1'b1; #1;
    total++; if (q_data !== 8'h11) $display("FAIL pp_head got %h exp 11", q_data); else passed++;
    step();
    mem_ready = 1'b0; q_pop = 1'b0; #1;
    total++; if (q_count !== 4'd1) $display("FAIL pp_count got %0d exp 1", q_count); else passed++;
    total++; if (q_data !== 8'h22) $display("FAIL pp_data got %h exp 22", q_data); else passed++;
    q_pop = 1'b1;
    step();
    step();
    q_pop = 1'b0; #1;
    total++; if (q_count !== 4'd0) $display("FAIL pp_empty_pop got %0d exp 0", q_count); else passed++;
  endtask

  task automatic test_bypass();
    do_reset(1'b0);
    step();
    mem_ready = 1'b1; mem_in = 8'h66; q_pop = 1'b1; #1;
`ifdef PREFETCH_BYPASS_EN
    total++; if (q_valid !== 1'b1) $display("FAIL byp_valid got %b exp 1", q_valid); else passed++;
    total++; if (q_data !== 8'h66) $display("FAIL byp_data got %h exp 66", q_data); else passed++;
    step();
    mem_ready = 1'b0; q_pop = 1'b0; #1;
    total++; if (q_count !== 4'd0) $display("FAIL byp_count got %0d exp 0", q_count); else passed++;
`else
    total++; if (q_valid !== 1'b0) $display("FAIL nobyp_valid got %b exp 0", q_valid); else passed++;
    step();
    mem_ready = 1'b0; q_pop = 1'b0; #1;
    total++; if (q_valid !== 1'b1) $display("FAIL nobyp_late_valid got %b exp 1", q_valid); else passed++;
    total++; if (q_data !== 8'h66) $display("FAIL nobyp_data got %h exp 66", q_data); else passed++;
    total++; if (q_count !== 4'd1) $display("FAIL nobyp_count got %0d exp 1", q_count); else passed++;
`endif
  endtask

  task automatic test_wrap();
    do_reset(1'b0);
    flush = 1'b1; flush_addr = 32'hFFFFFFFF; #1;
    step();
    flush = 1'b0; #1;
    fetch_byte(8'h42, 32'hFFFFFFFF);
    total++; if (mem_address !== 32'h00000000) $display("FAIL wrap_addr got %h exp 00000000", mem_address); else passed++;
    total++; if (q_data !== 8'h42) $display("FAIL wrap_data got %h exp 42", q_data); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_fetch();
    test_full();
    test_flush_wait();
    test_flush_same_cycle();
    test_bus_busy();
    test_locked();
    test_push_pop();
    test_bypass();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
